// File: rtl/rate_pkg.sv
// rate_pkg: divisor types, legal half-period range and the clamp helper.
// Shared by the speed-control block (producer) and rate_tick_gen (consumer)
// so both ends agree on what a legal divisor is.
package rate_pkg;

  localparam int unsigned DIV_W = 32;

  typedef logic [DIV_W-1:0] div_t;

  // 50 MHz / 2 / 22 kHz, rounded
  localparam div_t DEFAULT_DIV = 32'h470;
  localparam div_t MIN_DIV     = 32'h20;
  localparam div_t MAX_DIV     = 32'h8E0;

  // Unsigned, full-width compares; zero falls into the low clamp.
  function automatic div_t clamp_div(input div_t x);
    div_t r;
    r = x;
    if (x < MIN_DIV) begin
      r = MIN_DIV;
    end else if (x > MAX_DIV) begin
      r = MAX_DIV;
    end
    return r;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: turns a requested half-period into a 50% duty sample clock
// plus a one-cycle strobe on each rising edge of that clock.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       count when high, freeze everything when low
//   div_in       requested half-period in clk cycles
//   out_clk      generated sample clock
//   tick         one-clk pulse in the cycle out_clk becomes 1
//   div_active   half-period currently in use (after clamping)
//   div_clamped  high while div_active came from an out-of-range div_in
//
// div_in is only looked at on the terminal-count cycle, so every half-period
// runs on exactly one divisor value.
module rate_tick_gen #(
  parameter int unsigned      DIV_W       = rate_pkg::DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = rate_pkg::DEFAULT_DIV,
  parameter logic [DIV_W-1:0] MIN_DIV     = rate_pkg::MIN_DIV,
  parameter logic [DIV_W-1:0] MAX_DIV     = rate_pkg::MAX_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  output logic             out_clk,
  output logic             tick,
  output logic [DIV_W-1:0] div_active,
  output logic             div_clamped
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  // MIN_DIV >= 1 is what keeps div_active-1 from wrapping in the TC compare.
  if (!((MIN_DIV >= ONE) && (MIN_DIV <= DEFAULT_DIV) && (DEFAULT_DIV <= MAX_DIV))) begin : g_bad_range
    $error("rate_tick_gen: need 1 <= MIN_DIV <= DEFAULT_DIV <= MAX_DIV");
  end

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_next;
  logic             clamp_hit;
  logic             tc;

  assign tc = (cnt == (div_active - ONE));

  always_comb begin
    div_next  = div_in;
    clamp_hit = 1'b0;
    if (div_in < MIN_DIV) begin
      div_next  = MIN_DIV;
      clamp_hit = 1'b1;
    end else if (div_in > MAX_DIV) begin
      div_next  = MAX_DIV;
      clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      out_clk     <= 1'b0;
      tick        <= 1'b0;
      div_active  <= DEFAULT_DIV;
      div_clamped <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (tc) begin
          cnt         <= '0;
          out_clk     <= ~out_clk;
          // only the 0->1 toggle strobes
          tick        <= ~out_clk;
          div_active  <= div_next;
          div_clamped <= clamp_hit;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

// File: doc/rate_tick_gen.md
Name: rate_tick_gen

Overview:
- Consumer end of the 32-bit divisor interface driven by the speed-control block.
- Turns the divisor into a square-wave sample clock (out_clk) and a one-cycle strobe (tick) at each out_clk rising edge. The audio/flash-read path uses these to pace sample playback.
- Samples the divisor only at half-period boundaries, clamps it to a legal range and reports clamping.

Parameters:
- DIV_W, 32, width of divisor and counter.
- DEFAULT_DIV, 32'h470, half-period in clk cycles after reset (50 MHz / 2 / 22 kHz).
- MIN_DIV, 32'h20, smallest accepted half-period.
- MAX_DIV, 32'h8E0, largest accepted half-period.
- Legality rule: 1 <= MIN_DIV <= DEFAULT_DIV <= MAX_DIV. Elaboration fails otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run when high; freeze when low.
- div_in  in  DIV_W  requested half-period from speed control.
- out_clk  out  1  generated sample clock, 50% duty.
- tick  out  1  one-clk pulse in the cycle out_clk becomes 1.
- div_active  out  DIV_W  half-period currently in use (post-clamp).
- div_clamped  out  1  high while div_active came from a clamped div_in.

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, out_clk=0, tick=0, div_active=DEFAULT_DIV, div_clamped=0.
  - All outputs are registered.
- Counting, on each clk edge with enable=1:
  - If cnt == div_active-1, this is the terminal count (TC). Then:
    - cnt<=0
    - out_clk<=~out_clk
    - div_active<=clamp(div_in)
    - div_clamped<=(div_in<MIN_DIV)||(div_in>MAX_DIV)
    - tick<=~out_clk, i.e. high only on the 0->1 toggle.
  - Otherwise cnt<=cnt+1 and tick<=0.
- Period: out_clk half-period = div_active clk cycles; full period = 2*div_active. The first toggle after reset occurs on the DEFAULT_DIV-th enabled edge.
- clamp(x): MIN_DIV if x<MIN_DIV (this includes x=0), MAX_DIV if x>MAX_DIV, else x. Compares are unsigned and full width; there is no wrap.
- div_in changes mid-half-period are ignored until the next TC. A new value never truncates or extends the half-period already running. Each half-period uses exactly one divisor value.
- enable=0: cnt, out_clk, div_active and div_clamped hold, and tick<=0. Resuming continues from the held cnt; there is no restart.
- enable and TC in the same cycle: TC is processed only if enable=1.
- rst mid-period: immediate return to reset values. A pending divisor change is discarded.
- cnt never exceeds div_active-1. This holds because div_active >= MIN_DIV >= 1 at all times.

Decomposition:
- Package rate_pkg:
  - localparam DIV_W
  - typedef logic [DIV_W-1:0] div_t
  - DEFAULT_DIV, MIN_DIV, MAX_DIV constants
  - function clamp_div(div_t) returning div_t
  - The package is shared with speed control so both ends agree on the legal range.
- No sub-module. Counter, toggle and clamp fit in one block.

Test Plan (bench overrides DEFAULT_DIV=4, MIN_DIV=2, MAX_DIV=8):
- Reset release, enable=1, div_in=4 -> out_clk toggles every 4 clk (period 8). tick is high 1 cycle every 8 clk, coincident with out_clk 0->1. div_active=4, div_clamped=0.
- div_in changes 4->6 two cycles into a half-period -> that half-period still lasts 4 cycles, the next lasts 6, and div_active reads 6 from the TC cycle onward.
- div_in=1 and then div_in=0 -> div_active=2 and div_clamped=1 after the next TC. div_in=20 -> div_active=8, div_clamped=1. div_in=5 -> div_clamped returns to 0 at the next TC.
- enable dropped for 10 cycles at cnt=2 -> cnt/out_clk frozen and tick=0 throughout. After re-enable, TC occurs exactly 2 cycles later (div=4).
- rst asserted mid-period with div_active=6 -> outputs go to cnt=0, out_clk=0, tick=0, div_active=4, div_clamped=0 without waiting for a clk edge.
- Continuous run at div_in=MAX_DIV for 100 periods -> no cnt overflow and exactly 100 ticks.
